// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide unit for the execute stage.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle, with
// operand magnitudes and sign flags captured at start and sign correction
// applied after the last iteration. busy stalls ID/EX and earlier stages.
// Optional build macro MULDIV_EARLY_OUT_EN: divide-by-zero, signed divide
// overflow and multiplies with a zero operand finish without iterating.
module ex_muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned   CW      = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] LAST    = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [2:0]        op;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic [XLEN-1:0]   a_raw;
    logic              sign_a;
    logic              sign_b;
    logic              div_zero;
    logic              div_ovf;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   rem;
    logic [CW-1:0]     cnt;

    // operand decode for a request presented this cycle
    logic            in_a_signed;
    logic            in_b_signed;
    logic            in_sign_a;
    logic            in_sign_b;
    logic            in_is_div;
    logic            in_div_zero;
    logic            in_div_ovf;
    logic [XLEN-1:0] in_mag_a;
    logic [XLEN-1:0] in_mag_b;
`ifdef MULDIV_EARLY_OUT_EN
    logic            in_early;
    logic [XLEN-1:0] early_result;
`endif

    // Decode signedness, magnitudes and special cases from the incoming request
    always_comb begin
        in_is_div   = funct3[2];
        in_a_signed = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
        in_b_signed = in_a_signed && (funct3 != 3'b010);
        in_sign_a   = in_a_signed & rs1_data[XLEN-1];
        in_sign_b   = in_b_signed & rs2_data[XLEN-1];
        in_mag_a    = in_sign_a ? -rs1_data : rs1_data;
        in_mag_b    = in_sign_b ? -rs2_data : rs2_data;
        in_div_zero = in_is_div && (rs2_data == '0);
        in_div_ovf  = in_is_div && !funct3[0] && (rs1_data == MIN_NEG) && (rs2_data == '1);
`ifdef MULDIV_EARLY_OUT_EN
        in_early = in_div_zero || in_div_ovf ||
                   (!in_is_div && ((rs1_data == '0) || (rs2_data == '0)));
        if (!in_is_div)
            early_result = '0;
        else if (funct3[1])
            early_result = in_div_zero ? rs1_data : '0;
        else
            early_result = in_div_zero ? '1 : MIN_NEG;
`endif
    end

    // one iteration step and the sign-corrected, selected final result
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_shift;
    logic [XLEN-1:0]   rem_diff;
    logic              qbit;
    logic [XLEN-1:0]   rem_step;
    logic [2*XLEN-1:0] acc_step;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   remd;
    logic [XLEN-1:0]   final_result;

    // Next accumulator/remainder for this cycle's iteration, plus final result
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_a} : '0);
        rem_shift = {rem, acc[XLEN-1]};
        qbit      = (rem_shift >= {1'b0, mag_b});
        rem_diff  = rem_shift[XLEN-1:0] - mag_b;
        rem_step  = qbit ? rem_diff : rem_shift[XLEN-1:0];
        if (op[2])
            acc_step = {acc[2*XLEN-1:XLEN], acc[XLEN-2:0], qbit};
        else
            acc_step = {mul_sum, acc[XLEN-1:1]};

        prod = (sign_a ^ sign_b) ? -acc_step : acc_step;
        quo  = (sign_a ^ sign_b) ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
        remd = sign_a ? -rem_step : rem_step;

        case (op)
            3'b000:                 final_result = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_result = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_result = div_zero ? '1 : (div_ovf ? MIN_NEG : quo);
            default:                final_result = div_zero ? a_raw : (div_ovf ? '0 : remd);
        endcase
    end

    // Control FSM with registered busy/done/result and iteration datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            op       <= '0;
            mag_a    <= '0;
            mag_b    <= '0;
            a_raw    <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            div_zero <= 1'b0;
            div_ovf  <= 1'b0;
            acc      <= '0;
            rem      <= '0;
            cnt      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        op       <= funct3;
                        mag_a    <= in_mag_a;
                        mag_b    <= in_mag_b;
                        a_raw    <= rs1_data;
                        sign_a   <= in_sign_a;
                        sign_b   <= in_sign_b;
                        div_zero <= in_div_zero;
                        div_ovf  <= in_div_ovf;
                        acc      <= {{XLEN{1'b0}}, (in_is_div ? in_mag_a : in_mag_b)};
                        rem      <= '0;
                        cnt      <= '0;
                        busy     <= 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
                        if (in_early) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            result <= early_result;
                        end else begin
                            state <= RUN;
                        end
`else
                        state <= RUN;
`endif
                    end
                end
                RUN: begin
                    if (flush) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        acc <= acc_step;
                        rem <= rem_step;
                        cnt <= cnt + CW'(1);
                        if (cnt == LAST) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            result <= final_result;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed and randomized checks of ex_muldiv_unit
// against an arithmetic RV32M reference model.
`timescale 1ns/1ps
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int total = 0;
    int bad = 0;
    logic [31:0] last_res = '0;

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    ex_muldiv_unit #(.XLEN(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .flush    (flush),
        .funct3   (funct3),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub, p;
        logic [63:0] pu;
        int          ia, ib;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ub  = longint'({32'b0, b});
        ia  = $signed(a);
        ib  = $signed(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(ia / ib));
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : (ovf ? 32'd0 : 32'(ia % ib));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic special;
        if (f[2])
            special = (b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        else
            special = (a == 0) || (b == 0);
        return (EARLY && special) ? 1 : 33;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        int          n;
        int          lat;
        logic        busy_ok;
        logic [31:0] exp;
        exp = model(f, a, b);
        lat = exp_latency(f, a, b);
        @(negedge clk);
        start = 1'b1; funct3 = f; rs1_data = a; rs2_data = b;
        @(negedge clk);
        start = 1'b0; funct3 = 3'($urandom); rs1_data = $urandom; rs2_data = $urandom;
        n = 1;
        busy_ok = 1'b1;
        while (done !== 1'b1 && n < 60) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'(lat));
        check("busy_during_op", {31'b0, busy_ok}, 32'd1);
        check("busy_at_done", {31'b0, busy}, 32'd1);
        check("result", result, exp);
        last_res = exp;
        @(negedge clk);
        check("done_one_cycle", {31'b0, done}, 32'd0);
        check("busy_after_done", {31'b0, busy}, 32'd0);
    endtask

    logic [2:0]  dir_f [14] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                                3'd4, 3'd7, 3'd4, 3'd6, 3'd0, 3'd5};
    logic [31:0] dir_a [14] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                                32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd9};
    logic [31:0] dir_b [14] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                32'd2, 32'd2, 32'd7, 32'd7,
                                32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd12345, 32'd0};

    initial begin
        int          n;
        int          m;
        logic        saw_done;
        logic [31:0] exp;

        // reset and idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_busy", {31'b0, busy}, 32'd0);
            check("idle_done", {31'b0, done}, 32'd0);
            check("idle_result", result, 32'd0);
        end

        // directed operations including division corner cases
        for (int i = 0; i < 14; i++)
            run_op(dir_f[i], dir_a[i], dir_b[i]);

        // flush in the middle of a divide, then restart right away
        @(negedge clk);
        start = 1'b1; funct3 = 3'd4; rs1_data = 32'd1000; rs2_data = 32'd7;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (n < 10) begin @(negedge clk); n++; end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", {31'b0, busy}, 32'd0);
        check("flush_done", {31'b0, done}, 32'd0);
        check("flush_result_kept", result, last_res);
        start = 1'b1; funct3 = 3'd5; rs1_data = 32'd100; rs2_data = 32'd7;
        @(negedge clk);
        start = 1'b0;
        m = 1;
        while (done !== 1'b1 && m < 60) begin @(negedge clk); m++; end
        check("restart_latency", 32'(m), 32'd33);
        check("restart_result", result, model(3'd5, 32'd100, 32'd7));
        last_res = model(3'd5, 32'd100, 32'd7);

        // start held high: requests during busy are ignored
        @(negedge clk);
        start = 1'b1; funct3 = 3'd0; rs1_data = 32'd123456; rs2_data = 32'd789;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (done !== 1'b1) begin
                funct3 = 3'($urandom); rs1_data = $urandom; rs2_data = $urandom;
            end
        end while (done !== 1'b1 && n < 60);
        check("held_first_latency", 32'(n), 32'd33);
        check("held_first_result", result, model(3'd0, 32'd123456, 32'd789));
        funct3 = 3'd4; rs1_data = 32'hFFFF_FC18; rs2_data = 32'd3;
        m = 0;
        do begin @(negedge clk); m++; end while (done !== 1'b1 && m < 60);
        start = 1'b0;
        check("held_second_spacing", 32'(m), 32'd34);
        check("held_second_result", result, model(3'd4, 32'hFFFF_FC18, 32'd3));
        last_res = model(3'd4, 32'hFFFF_FC18, 32'd3);
        @(negedge clk);
        @(negedge clk);
        check("held_no_third_op", {31'b0, busy}, 32'd0);

        // start and flush together in idle
        start = 1'b1; flush = 1'b1; funct3 = 3'd0; rs1_data = 32'd3; rs2_data = 32'd4;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("startflush_busy", {31'b0, busy}, 32'd0);
        saw_done = 1'b0;
        repeat (35) begin @(negedge clk); if (done === 1'b1) saw_done = 1'b1; end
        check("startflush_no_done", {31'b0, saw_done}, 32'd0);
        check("startflush_result", result, last_res);

        // flush during the done cycle: pulse and result still land
        exp = model(3'd7, 32'd1000, 32'd13);
        @(negedge clk);
        start = 1'b1; funct3 = 3'd7; rs1_data = 32'd1000; rs2_data = 32'd13;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (done !== 1'b1 && n < 60) begin @(negedge clk); n++; end
        check("flushdone_latency", 32'(n), 32'd33);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flushdone_busy", {31'b0, busy}, 32'd0);
        check("flushdone_result", result, exp);
        last_res = exp;

        // reset in the middle of an operation
        @(negedge clk);
        start = 1'b1; funct3 = 3'd3; rs1_data = 32'hDEAD_BEEF; rs2_data = 32'h1234_5678;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset_busy", {31'b0, busy}, 32'd0);
        check("midreset_result", result, 32'd0);
        saw_done = 1'b0;
        repeat (30) begin @(negedge clk); if (done === 1'b1) saw_done = 1'b1; end
        check("midreset_no_done", {31'b0, saw_done}, 32'd0);
        last_res = '0;

        // randomized operations
        for (int i = 0; i < 40; i++)
            run_op(3'($urandom_range(0, 7)), rand_operand(), rand_operand());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the execute stage.
- Consumes operands and funct3 from the ID/EX pipeline register.
- Multi-cycle; asserts busy so the hazard logic stalls ID/EX and earlier stages until the result is written toward EX/MEM.
- One operation in flight at a time; radix-2 shift-add multiply, restoring divide.

Parameters:
XLEN, 32, operand/result width; pipeline uses 32 only; iteration count = XLEN, counter width = $clog2(XLEN)+1

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
start  input  1  request new op; sampled only in IDLE
flush  input  1  abort in-flight op (branch mispredict / pipeline flush)
funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1_data  input  XLEN  operand a (dividend/multiplicand)
rs2_data  input  XLEN  operand b (divisor/multiplier)
busy  output  1  state != IDLE; drives EX stall
done  output  1  one-cycle pulse, result valid
result  output  XLEN  final result

Behaviour:
- States: IDLE, RUN, DONE.
- Reset: state=IDLE; busy=0, done=0, result=0; counter, accumulators and sign flags cleared. Reset mid-operation aborts with no done pulse.
- IDLE, start=1, flush=0 at edge k:
  - Latch funct3.
  - Latch operand magnitudes and result sign:
    - MUL/MULH/DIV/REM: both operands signed.
    - MULHSU: rs1 signed, rs2 unsigned.
    - MULHU/DIVU/REMU: unsigned.
  - Counter=0; go to RUN.
- RUN: one iteration per cycle, 32 iterations, counter increments.
  - Multiply: 64-bit product accumulator, shift-add on LSB of multiplier.
  - Divide: restoring; 33-bit partial remainder; quotient bit = no-borrow.
  - After the 32nd iteration, apply sign correction and register result: go to DONE.
- Sign correction:
  - Product negated if operand signs differ (signed forms).
  - Quotient negated if signs differ.
  - Remainder takes the dividend's sign.
- Result selection:
  - MUL = low 32 bits of the product.
  - MULH/MULHSU/MULHU = high 32 bits.
  - DIV/DIVU = quotient.
  - REM/REMU = remainder.
- DONE: done=1 for exactly one cycle; result valid; next state IDLE.
- Latency: done is high in cycle k+33 (start sampled at edge k); busy high cycles k+1..k+33.
- Back-to-back: start may be sampled in the cycle immediately after done, since busy=0 then.
- result holds its value after done until the next DONE. It does not change on start, flush or idle.
- Special cases (RISC-V mandated, full latency unless the optional feature is enabled):
  - Divide by zero: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> rs1.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
- start while busy: ignored; no queuing.
- flush: forces IDLE at the next edge from any state. No done is produced; result is unchanged.
  - flush and start in the same IDLE cycle: flush wins, start dropped.
  - flush during DONE: the done pulse in that cycle still asserts; state -> IDLE.
- Operand inputs are not required to be stable after the start cycle.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: divide-by-zero, signed overflow and MUL-family ops with either operand zero skip RUN. IDLE -> DONE directly with the special result; done in cycle k+1; busy high only cycle k+1.
- Undefined: every op takes the full 33-cycle latency, with special results applied at the end of RUN.

Test Plan:
- Reset then idle 5 cycles -> busy=0, done=0, result=0 throughout.
- MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB. MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF. Each: done exactly at k+33, one cycle wide.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2.
- Division corner cases:
  - DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same -> 0.
  - Latency 33 without MULDIV_EARLY_OUT_EN, 1 with it.
- Flush at cycle k+10 of a DIV -> busy=0 from k+11, no done, result keeps the prior value. New start at k+11 completes normally at k+44.
- start held high continuously with alternating MUL/DIV -> ops accepted only when busy=0; second op's done lands 34 cycles after the first's done. start during busy is ignored. Simultaneous start+flush in IDLE -> no op launched.
